// File: rtl/l2_cache_nway_pkg.sv
// Shared types and field-width helpers for the parametrised set-associative L2 cache.
package lc3b_types;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} lc3b_l2n_state_t;

    function automatic int off_width(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_width, input int sets, input int line_bits);
        return addr_width - idx_width(sets) - off_width(line_bits);
    endfunction

endpackage

// File: rtl/l2_cache_nway_plru.sv
// Per-set tree pseudo-LRU: a heap of WAYS-1 bits per set, bit=0 points at the lower half.
module l2_plru_tree #(
    parameter int WAYS = 8,
    parameter int SETS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(SETS)-1:0] index,
    input  logic                    access_valid,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int NODES  = WAYS - 1;
    localparam int LEVELS = $clog2(WAYS);

    logic [NODES-1:0] bits_q [SETS];
    logic [NODES-1:0] upd_mask;
    logic [NODES-1:0] upd_val;

    always_comb begin : victim_walk
        int   node;
        logic b;
        node       = 0;
        b          = 1'b0;
        victim_way = '0;
        for (int l = 0; l < LEVELS; l++) begin
            b = 1'b0;
            for (int n = 0; n < NODES; n++)
                if (n == node) b = bits_q[index][n];
            victim_way[LEVELS-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
    end

    // Each node on the accessed path is turned to point away from the accessed way.
    always_comb begin : access_walk
        int   node;
        logic b;
        node     = 0;
        b        = 1'b0;
        upd_mask = '0;
        upd_val  = '0;
        for (int l = 0; l < LEVELS; l++) begin
            b = access_way[LEVELS-1-l];
            for (int n = 0; n < NODES; n++)
                if (n == node) begin
                    upd_mask[n] = 1'b1;
                    upd_val[n]  = ~b;
                end
            node = 2 * node + 1 + int'(b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
        end else if (access_valid) begin
            bits_q[index] <= (bits_q[index] & ~upd_mask) | (upd_val & upd_mask);
        end
    end

endmodule

// File: rtl/l2_cache_nway.sv
// Write-back set-associative L2 cache: tag/valid/dirty/data arrays, PLRU replacement,
// miss controller and saturating hit/miss counters between the L1 arbiter and memory.
module l2_cache_nway import lc3b_types::*; #(
    parameter int WAYS       = 8,
    parameter int SETS       = 8,
    parameter int LINE_BITS  = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_BITS-1:0]  mem_wdata,
    output logic [LINE_BITS-1:0]  mem_rdata,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_BITS-1:0]  pmem_wdata,
    input  logic [LINE_BITS-1:0]  pmem_rdata,
    input  logic                  pmem_resp,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int OFF   = off_width(LINE_BITS);
    localparam int IDX   = idx_width(SETS);
    localparam int TAG   = tag_width(ADDR_WIDTH, SETS, LINE_BITS);
    localparam int WAY_W = $clog2(WAYS);

    lc3b_l2n_state_t state, state_next;

    logic [TAG-1:0]       req_tag;
    logic [IDX-1:0]       req_idx;
    logic                 offset_unused;

    logic [SETS-1:0]      valid_q [WAYS];
    logic [SETS-1:0]      dirty_q [WAYS];
    logic [TAG-1:0]       tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];

    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     plru_victim;
    logic [WAY_W-1:0]     victim_sel;
    logic [WAY_W-1:0]     victim_q;
    logic                 refill_q;

    assign req_tag       = mem_address[ADDR_WIDTH-1 -: TAG];
    assign req_idx       = mem_address[OFF +: IDX];
    assign offset_unused = ^mem_address[OFF-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    // Descending scan so the lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        victim_sel = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w][req_idx]) victim_sel = WAY_W'(w);
    end

    l2_plru_tree #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk          (clk),
        .rst_n        (rst_n),
        .index        (req_idx),
        .access_valid (state == COMPARE && hit),
        .access_way   (hit_way),
        .victim_way   (plru_victim)
    );

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    mem_resp   = 1'b1;
                    mem_rdata  = data_q[hit_way][req_idx];
                    state_next = IDLE;
                end else if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][req_idx], req_idx, {OFF{1'b0}}};
                pmem_wdata   = data_q[victim_q][req_idx];
                if (pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {OFF{1'b0}}};
                if (pmem_resp) state_next = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    // refill_q keeps the completing re-compare after a fill from counting as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            refill_q   <= 1'b0;
            victim_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            state <= state_next;
            if (state == COMPARE) begin
                if (hit) begin
                    refill_q <= 1'b0;
                    if (!refill_q && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                    if (mem_write) dirty_q[hit_way][req_idx] <= 1'b1;
                end else begin
                    victim_q <= victim_sel;
                    refill_q <= 1'b1;
                    if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                end
            end
            if (state == FILL && pmem_resp) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && mem_write)
            data_q[hit_way][req_idx] <= mem_wdata;
        if (state == FILL && pmem_resp) begin
            data_q[victim_q][req_idx] <= pmem_rdata;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end

endmodule
